// File: rtl/imem_load_ctrl_pkg.sv
// Shared build-time sizes for the boot loader plus its FSM state encodings.
// Sizes can be overridden from the command line via `PC_WIDTH, `INST_WIDTH, `IMEM_DEPTH.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef IMEM_DEPTH
`define IMEM_DEPTH 1024
`endif
`ifndef FILE_PATH
`define FILE_PATH "imem.hex"
`endif

package imem_load_ctrl_pkg;

    localparam int unsigned PC_WIDTH   = `PC_WIDTH;
    localparam int unsigned INST_WIDTH = `INST_WIDTH;
    localparam int unsigned IMEM_DEPTH = `IMEM_DEPTH;
    localparam string       FILE_PATH  = `FILE_PATH;

    localparam logic [PC_WIDTH-1:0] LOAD_BASE = '0;
    localparam int unsigned         MAX_WORDS = IMEM_DEPTH / 4;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLen0  = 3'd1,
        StLen1  = 3'd2,
        StData  = 3'd3,
        StWrite = 3'd4,
        StCsum  = 3'd5,
        StDone  = 3'd6,
        StErr   = 3'd7
    } load_state_e;

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles four little-endian stream bytes into one instruction word.
module imem_byte_packer
    import imem_load_ctrl_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clr_i,
    input  logic                  push_i,
    input  logic [7:0]            byte_i,
    output logic [INST_WIDTH-1:0] word_o,
    output logic                  full_o
);

    logic [1:0]            idx_q, idx_d;
    logic [INST_WIDTH-1:0] word_q, word_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clr_i) begin
            idx_d  = '0;
            word_d = '0;
        end else if (push_i) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_i;
            idx_d                        = idx_q + 2'd1;
        end
    end

    // Word view includes the byte being pushed so the 4th byte completes it this cycle.
    assign word_o = word_d;
    assign full_o = push_i & ~clr_i & (idx_q == 2'd3);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// Boot loader: framed byte stream (LE word count, LE words) -> IMEM word writes, holds CPU.
// Optional trailing XOR checksum byte enabled by IMEM_LOAD_CSUM_EN.
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  s_valid_i,
    input  logic [7:0]            s_data_i,
    output logic                  s_ready_o,
    output logic                  wr_en_o,
    output logic [PC_WIDTH-1:0]   wr_addr_o,
    output logic [INST_WIDTH-1:0] wr_data_o,
    output logic                  cpu_hold_o,
    output logic                  done_o,
    output logic                  err_o
);

`ifdef IMEM_LOAD_CSUM_EN
    localparam load_state_e StLast = StCsum;
`else
    localparam load_state_e StLast = StDone;
`endif

    load_state_e           state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [PC_WIDTH-1:0]   addr_q, addr_d;
    logic [INST_WIDTH-1:0] data_q, data_d;
`ifdef IMEM_LOAD_CSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic                  accept;
    logic                  pack_clr;
    logic                  pack_push;
    logic                  pack_full;
    logic [INST_WIDTH-1:0] pack_word;
    logic [15:0]           len;

    imem_byte_packer u_packer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (pack_clr),
        .push_i  (pack_push),
        .byte_i  (s_data_i),
        .word_o  (pack_word),
        .full_o  (pack_full)
    );

    always_comb begin
        s_ready_o = (state_q == StLen0) || (state_q == StLen1) ||
                    (state_q == StData) || (state_q == StCsum);
    end

    assign accept     = s_valid_i & s_ready_o;
    assign len        = {s_data_i, cnt_q[7:0]};
    assign wr_en_o    = (state_q == StWrite);
    assign wr_addr_o  = addr_q;
    assign wr_data_o  = data_q;
    assign cpu_hold_o = (state_q != StDone);
    assign done_o     = (state_q == StDone);
    assign err_o      = (state_q == StErr);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        pack_clr  = 1'b0;
        pack_push = 1'b0;
`ifdef IMEM_LOAD_CSUM_EN
        csum_d    = csum_q;
`endif
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start_i) begin
                    state_d  = StLen0;
                    cnt_d    = '0;
                    addr_d   = LOAD_BASE;
                    pack_clr = 1'b1;
`ifdef IMEM_LOAD_CSUM_EN
                    csum_d   = '0;
`endif
                end
            end
            StLen0: begin
                if (accept) begin
                    cnt_d[7:0] = s_data_i;
                    state_d    = StLen1;
                end
            end
            StLen1: begin
                if (accept) begin
                    cnt_d = len;
                    if (len == 16'd0) begin
                        state_d = StLast;
                    end else if (32'(len) > MAX_WORDS) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                pack_push = accept;
                if (accept) begin
`ifdef IMEM_LOAD_CSUM_EN
                    csum_d = csum_q ^ s_data_i;
`endif
                    if (pack_full) begin
                        data_d  = pack_word;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                addr_d  = addr_q + PC_WIDTH'(4);
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? StLast : StData;
            end
`ifdef IMEM_LOAD_CSUM_EN
            StCsum: begin
                if (accept) begin
                    state_d = (s_data_i == csum_q) ? StDone : StErr;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= LOAD_BASE;
            data_q  <= '0;
`ifdef IMEM_LOAD_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef IMEM_LOAD_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed self-checking bench for imem_load_ctrl (follows IMEM_LOAD_CSUM_EN when defined).
module tb_imem_load_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, s_valid;
    logic [7:0]  s_data;
    logic        s_ready_o, wr_en_o, cpu_hold_o, done_o, err_o;
    logic [31:0] wr_addr_o, wr_data_o;

    int checks = 0;
    int errors = 0;
    int rdy_bad = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    always #5 clk = ~clk;

    imem_load_ctrl dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .s_valid_i  (s_valid),
        .s_data_i   (s_data),
        .s_ready_o  (s_ready_o),
        .wr_en_o    (wr_en_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .cpu_hold_o (cpu_hold_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    // Write monitor; s_ready must be low whenever wr_en is high.
    always @(negedge clk) begin
        if (wr_en_o) begin
            wa.push_back(wr_addr_o);
            wd.push_back(wr_data_o);
            if (s_ready_o) rdy_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qa(input int i);
        return (i < wa.size()) ? wa[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] qd(input int i);
        return (i < wd.size()) ? wd[i] : 32'hxxxx_xxxx;
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic taken;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        taken   = 1'b0;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge clk);
            taken = s_ready_o;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        if (!taken) chk("byte_accept_timeout", {31'd0, taken}, 32'd1);
    endtask

    task automatic wait_end();
        logic fin;
        fin = 1'b0;
        for (int i = 0; i < 40 && !fin; i++) begin
            @(negedge clk);
            fin = done_o | err_o;
        end
        @(posedge clk); #1;
        chk("end_reached", {31'd0, fin}, 32'd1);
    endtask

    logic [7:0] s1 [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                            8'h93, 8'h00, 8'h10, 8'h00};

    task automatic send_s1(input logic gaps);
        for (int i = 0; i < 10; i++) send_byte(s1[i], gaps ? int'($urandom_range(1, 5)) : 0);
`ifdef IMEM_LOAD_CSUM_EN
        send_byte(8'h90, gaps ? int'($urandom_range(1, 5)) : 0);
`endif
    endtask

    int base;

    initial begin
        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", {31'd0, s_ready_o}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en_o}, 32'd0);
        chk("rst_wr_addr", wr_addr_o, 32'd0);
        chk("rst_wr_data", wr_data_o, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_cpu_hold", {31'd0, cpu_hold_o}, 32'd1);
        @(posedge clk); #1;

        // 1: two-word load, no gaps
        base = wa.size();
        pulse_start();
        chk("t1_hold_busy", {31'd0, cpu_hold_o}, 32'd1);
        chk("t1_ready_len0", {31'd0, s_ready_o}, 32'd1);
        send_s1(1'b0);
        wait_end();
        chk("t1_nwr", 32'(wa.size() - base), 32'd2);
        chk("t1_a0", qa(base), 32'h0);
        chk("t1_d0", qd(base), 32'h0000_0013);
        chk("t1_a1", qa(base + 1), 32'h4);
        chk("t1_d1", qd(base + 1), 32'h0010_0093);
        chk("t1_done", {31'd0, done_o}, 32'd1);
        chk("t1_hold", {31'd0, cpu_hold_o}, 32'd0);
        chk("t1_ready_done", {31'd0, s_ready_o}, 32'd0);

        // 2: reload from DONE with random bubbles
        base = wa.size();
        pulse_start();
        chk("t2_hold_reload", {31'd0, cpu_hold_o}, 32'd1);
        chk("t2_done_clr", {31'd0, done_o}, 32'd0);
        send_s1(1'b1);
        wait_end();
        chk("t2_nwr", 32'(wa.size() - base), 32'd2);
        chk("t2_a0", qa(base), 32'h0);
        chk("t2_d0", qd(base), 32'h0000_0013);
        chk("t2_a1", qa(base + 1), 32'h4);
        chk("t2_d1", qd(base + 1), 32'h0010_0093);
        chk("t2_done", {31'd0, done_o}, 32'd1);
        chk("t2_ready_on_write", 32'(rdy_bad), 32'd0);

        // 3: 257 words exceeds 1024-byte IMEM
        base = wa.size();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        chk("t3_err", {31'd0, err_o}, 32'd1);
        chk("t3_hold", {31'd0, cpu_hold_o}, 32'd1);
        chk("t3_ready", {31'd0, s_ready_o}, 32'd0);
        chk("t3_nwr", 32'(wa.size() - base), 32'd0);
        @(posedge clk); #1;
        pulse_start();
        chk("t3_err_clr", {31'd0, err_o}, 32'd0);
        send_s1(1'b0);
        wait_end();
        chk("t3_done", {31'd0, done_o}, 32'd1);
        chk("t3_nwr2", 32'(wa.size() - base), 32'd2);

        // 4: reset mid-word
        base = wa.size();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t4_s_ready", {31'd0, s_ready_o}, 32'd0);
        chk("t4_wr_en", {31'd0, wr_en_o}, 32'd0);
        chk("t4_wr_addr", wr_addr_o, 32'd0);
        chk("t4_wr_data", wr_data_o, 32'd0);
        chk("t4_done", {31'd0, done_o}, 32'd0);
        chk("t4_err", {31'd0, err_o}, 32'd0);
        chk("t4_hold", {31'd0, cpu_hold_o}, 32'd1);
        repeat (3) @(negedge clk);
        chk("t4_nwr", 32'(wa.size() - base), 32'd0);
        @(posedge clk); #1;

`ifdef IMEM_LOAD_CSUM_EN
        // 5: checksum match then mismatch
        base = wa.size();
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        wait_end();
        chk("t5_done", {31'd0, done_o}, 32'd1);
        chk("t5_nwr", 32'(wa.size() - base), 32'd1);
        base = wa.size();
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h12, 0);
        wait_end();
        chk("t5_err", {31'd0, err_o}, 32'd1);
        chk("t5_hold", {31'd0, cpu_hold_o}, 32'd1);
        chk("t5_nwr_bad", 32'(wa.size() - base), 32'd1);
`endif

        // 6: zero-length load, then start ignored mid-DATA
        base = wa.size();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef IMEM_LOAD_CSUM_EN
        send_byte(8'h00, 0);
`endif
        wait_end();
        chk("t6_done", {31'd0, done_o}, 32'd1);
        chk("t6_nwr", 32'(wa.size() - base), 32'd0);
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef IMEM_LOAD_CSUM_EN
        send_byte(8'h13, 0);
`endif
        wait_end();
        chk("t6_busy_done", {31'd0, done_o}, 32'd1);
        chk("t6_busy_nwr", 32'(wa.size() - base), 32'd1);
        chk("t6_busy_a0", qa(base), 32'h0);
        chk("t6_busy_d0", qd(base), 32'h0000_0013);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
